ifu_ctrl: RTL

Fetch controller that sequences the PC register and the instruction-memory port. It decides when the PC register is written and with what value: sequential PC+4, or a redirect target from execute. It issues one outstanding fetch at a time to instruction memory and presents the returned instruction to decode with a valid/ready handshake. It sits between the PC register, the instruction-memory interface and the decode stage.

---
 rtl/ifu_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ifu_ctrl.sv
// Instruction fetch controller: sequences PC register writes and a single
// outstanding instruction-memory fetch, handing instructions to decode.
module ifu_ctrl #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h80000000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_pc,
  output logic             o_ifu_wen,
  output logic [WIDTH-1:0] o_next_pc,
  output logic             o_imem_req,
  output logic [WIDTH-1:0] o_imem_addr,
  input  logic             i_imem_gnt,
  input  logic             i_imem_rvalid,
  input  logic [31:0]      i_imem_rdata,
  input  logic             i_imem_err,
  output logic             o_inst_valid,
  output logic [31:0]      o_inst,
  output logic [WIDTH-1:0] o_inst_pc,
  output logic             o_inst_err,
  input  logic             i_id_ready,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_pc,
  input  logic             i_halt,
  output logic             o_halted,
  output logic [31:0]      o_fetch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_HALT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             discard;
  logic             discard_nxt;
  logic             capture_pc;
  logic             latch_rsp;
  logic             accept;
  logic [WIDTH-1:0] redirect_target;
  logic [WIDTH-1:0] seq_pc;

  assign redirect_target = {i_redirect_pc[WIDTH-1:2], 2'b00};
  assign seq_pc          = i_pc + WIDTH'(4);
  assign o_imem_addr     = i_pc;
  assign o_halted        = (state == S_HALT);

  // Redirect outranks every other event outside HALT; a redirect racing an
  // accepted request marks the eventual response for discard.
  always_comb begin
    state_nxt    = state;
    discard_nxt  = discard;
    o_ifu_wen    = 1'b0;
    o_next_pc    = RESET_PC;
    o_imem_req   = 1'b0;
    o_inst_valid = 1'b0;
    capture_pc   = 1'b0;
    latch_rsp    = 1'b0;
    accept       = 1'b0;

    case (state)
      S_IDLE: begin
        if (i_redirect) begin
          o_ifu_wen = 1'b1;
          o_next_pc = redirect_target;
          state_nxt = S_REQ;
        end else if (i_halt) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_REQ;
        end
      end

      S_REQ: begin
        o_imem_req = 1'b1;
        capture_pc = i_imem_gnt;
        if (i_redirect) begin
          o_ifu_wen = 1'b1;
          o_next_pc = redirect_target;
          if (i_imem_gnt) begin
            state_nxt   = S_WAIT;
            discard_nxt = 1'b1;
          end
        end else if (i_imem_gnt) begin
          state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (i_redirect) begin
          o_ifu_wen = 1'b1;
          o_next_pc = redirect_target;
          if (i_imem_rvalid) begin
            state_nxt   = S_REQ;
            discard_nxt = 1'b0;
          end else begin
            discard_nxt = 1'b1;
          end
        end else if (i_imem_rvalid) begin
          if (discard) begin
            discard_nxt = 1'b0;
            state_nxt   = S_REQ;
          end else begin
            latch_rsp = 1'b1;
            state_nxt = S_VALID;
          end
        end
      end

      S_VALID: begin
        if (i_redirect) begin
          o_ifu_wen = 1'b1;
          o_next_pc = redirect_target;
          state_nxt = S_REQ;
        end else begin
          o_inst_valid = 1'b1;
          if (i_id_ready) begin
            o_ifu_wen = 1'b1;
            o_next_pc = seq_pc;
            accept    = 1'b1;
            state_nxt = i_halt ? S_HALT : S_REQ;
          end
        end
      end

      S_HALT: begin
        state_nxt = S_HALT;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Controller state plus the registered instruction presented to decode.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      discard     <= 1'b0;
      o_inst      <= 32'd0;
      o_inst_pc   <= '0;
      o_inst_err  <= 1'b0;
      o_fetch_cnt <= 32'd0;
    end else begin
      state   <= state_nxt;
      discard <= discard_nxt;
      if (capture_pc) begin
        o_inst_pc <= i_pc;
      end
      if (latch_rsp) begin
        o_inst     <= i_imem_rdata;
        o_inst_err <= i_imem_err;
      end
      if (accept) begin
        o_fetch_cnt <= o_fetch_cnt + 32'd1;
      end
    end
  end

endmodule
